// File: rtl/pe_accumulator_if.sv
// Handshake and data bundle between the PE multiplier array, the accumulator
// and the output feature-map writer. The slave modport is the accumulator side.
interface pe_accumulator_if #(
  parameter int PROD_W = 25,
  parameter int ACC_W  = 32,
  parameter int NUM_K  = 4,
  parameter int TAPS   = 9
);
  logic                          in_valid;
  logic                          in_last;
  logic                          in_ready;
  logic [NUM_K*TAPS*PROD_W-1:0]  prod_in;
  logic                          out_valid;
  logic                          out_ready;
  logic [NUM_K*ACC_W-1:0]        out_data;
  logic [NUM_K-1:0]              out_sat;
  logic [15:0]                   beat_cnt;

  modport master (
    output in_valid, in_last, prod_in, out_ready,
    input  in_ready, out_valid, out_data, out_sat, beat_cnt
  );

  modport slave (
    input  in_valid, in_last, prod_in, out_ready,
    output in_ready, out_valid, out_data, out_sat, beat_cnt
  );
endinterface

// File: rtl/pe_accumulator.sv
// Reduces each kernel's taps per beat, accumulates across input-channel beats
// with saturation, and hands one result word per kernel to the writer.
// Two pipeline stages (tap sum, accumulate) share a single advance condition
// so a stalled output freezes the whole pipe without dropping beats.
module pe_accumulator #(
  parameter int PROD_W  = 25,
  parameter int ACC_W   = 32,
  parameter int NUM_K   = 4,
  parameter int TAPS    = 9,
  parameter bit RELU_EN = 1'b1
) (
  input logic             clk,
  input logic             rst,
  pe_accumulator_if.slave bus
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic                    adv;
  logic signed [ACC_W-1:0] tap_sum [NUM_K];
  logic signed [ACC_W-1:0] s1_sum  [NUM_K];
  logic                    s1_valid;
  logic                    s1_last;
  logic signed [ACC_W-1:0] acc     [NUM_K];
  logic signed [ACC_W-1:0] nxt     [NUM_K];
  logic [NUM_K-1:0]        ovf;
  logic [NUM_K-1:0]        sat;
  logic                    first;
  logic [15:0]             beat_cnt_r;
  logic                    out_valid_r;
  logic [NUM_K*ACC_W-1:0]  out_data_r;
  logic [NUM_K-1:0]        out_sat_r;

  // The pipe moves unless a result is waiting on a downstream that is not ready.
  assign adv           = !(out_valid_r && !bus.out_ready);
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_sat   = out_sat_r;
  assign bus.beat_cnt  = beat_cnt_r;

  // Sign-extend every tap of a kernel and reduce them to one beat sum.
  always_comb begin
    logic [PROD_W-1:0] p;
    p = '0;
    for (int k = 0; k < NUM_K; k++) begin
      tap_sum[k] = '0;
      for (int t = 0; t < TAPS; t++) begin
        p = bus.prod_in[(k*TAPS+t)*PROD_W +: PROD_W];
        tap_sum[k] = tap_sum[k] + {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
      end
    end
  end

  // One extra bit catches overflow of the running sum; clamp to the rail it crossed.
  always_comb begin
    logic signed [ACC_W-1:0] base;
    logic [ACC_W:0]          wide;
    base = '0;
    wide = '0;
    for (int k = 0; k < NUM_K; k++) begin
      base   = first ? '0 : acc[k];
      wide   = {base[ACC_W-1], base} + {s1_sum[k][ACC_W-1], s1_sum[k]};
      ovf[k] = wide[ACC_W] ^ wide[ACC_W-1];
      if (!ovf[k])
        nxt[k] = wide[ACC_W-1:0];
      else if (wide[ACC_W])
        nxt[k] = ACC_MIN;
      else
        nxt[k] = ACC_MAX;
    end
  end

  // Stage 1 register: capture the beat's kernel sums and its last flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int k = 0; k < NUM_K; k++) s1_sum[k] <= '0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s1_last  <= bus.in_last;
      if (bus.in_valid)
        for (int k = 0; k < NUM_K; k++) s1_sum[k] <= tap_sum[k];
    end
  end

  // Stage 2: accumulate mid-group beats, or close the group and publish the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_K; k++) acc[k] <= '0;
      sat         <= '0;
      first       <= 1'b1;
      beat_cnt_r  <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sat_r   <= '0;
    end else if (adv) begin
      out_valid_r <= 1'b0;
      if (s1_valid) begin
        if (!s1_last) begin
          for (int k = 0; k < NUM_K; k++) acc[k] <= nxt[k];
          sat   <= sat | ovf;
          first <= 1'b0;
          if (beat_cnt_r != 16'hFFFF) beat_cnt_r <= beat_cnt_r + 16'd1;
        end else begin
          for (int k = 0; k < NUM_K; k++) begin
            out_data_r[k*ACC_W +: ACC_W] <= (RELU_EN && nxt[k][ACC_W-1]) ? '0 : nxt[k];
            acc[k] <= '0;
          end
          out_sat_r   <= sat | ovf;
          out_valid_r <= 1'b1;
          sat         <= '0;
          first       <= 1'b1;
          beat_cnt_r  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_accumulator.sv
// Bench for pe_accumulator: directed vector table, hand-written stall and
// reset sequences, then random traffic scored against a group-level model.
// Two instances (ReLU on / off) see identical stimulus.
module tb_pe_accumulator;

  localparam int PROD_W = 25;
  localparam int ACC_W  = 32;
  localparam int NUM_K  = 4;
  localparam int TAPS   = 9;
  localparam int PW     = NUM_K*TAPS*PROD_W;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct {
    int       nbeats;
    int       p0;
    int       pr;
    int       e0;
    int       er;
    logic [3:0] esat;
  } vec_t;

  typedef struct packed {
    logic [3:0]   sat;
    logic [127:0] data;
  } res_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_last;
  logic          out_ready;
  logic [PW-1:0] prod;

  int     n_tests;
  int     n_fail;
  res_t   exp_q[$];
  longint g_acc[NUM_K];
  logic [3:0] g_sat;
  vec_t   vecs[7];

  pe_accumulator_if if1 ();
  pe_accumulator_if if0 ();

  assign if1.in_valid  = in_valid;
  assign if1.in_last   = in_last;
  assign if1.prod_in   = prod;
  assign if1.out_ready = out_ready;
  assign if0.in_valid  = in_valid;
  assign if0.in_last   = in_last;
  assign if0.prod_in   = prod;
  assign if0.out_ready = out_ready;

  pe_accumulator #(.RELU_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(if1));
  pe_accumulator #(.RELU_EN(1'b0)) dut_raw (.clk(clk), .rst(rst), .bus(if0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint kval(input logic [127:0] d, input int k);
    logic signed [31:0] w;
    w = d[k*32 +: 32];
    return longint'(w);
  endfunction

  function automatic longint relu(input longint v);
    return (v < 0) ? 64'sd0 : v;
  endfunction

  function automatic logic [PW-1:0] fill_prod(input int p0, input int pr);
    logic [PW-1:0] v;
    logic [PROD_W-1:0] a;
    logic [PROD_W-1:0] b;
    a = PROD_W'(p0);
    b = PROD_W'(pr);
    v = '0;
    for (int k = 0; k < NUM_K; k++)
      for (int t = 0; t < TAPS; t++)
        v[(k*TAPS+t)*PROD_W +: PROD_W] = (k == 0) ? a : b;
    return v;
  endfunction

  task automatic check_value(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: whole-group arithmetic on every accepted beat, clamped per step.
  task automatic model_beat();
    longint s;
    res_t   r;
    for (int k = 0; k < NUM_K; k++) begin
      s = 0;
      for (int t = 0; t < TAPS; t++)
        s += longint'($signed(prod[(k*TAPS+t)*PROD_W +: PROD_W]));
      g_acc[k] += s;
      if (g_acc[k] > SMAX) begin g_acc[k] = SMAX; g_sat[k] = 1'b1; end
      if (g_acc[k] < SMIN) begin g_acc[k] = SMIN; g_sat[k] = 1'b1; end
    end
    if (in_last) begin
      r.sat = g_sat;
      for (int k = 0; k < NUM_K; k++) r.data[k*32 +: 32] = g_acc[k][31:0];
      exp_q.push_back(r);
      for (int k = 0; k < NUM_K; k++) g_acc[k] = 0;
      g_sat = '0;
    end
  endtask

  task automatic scoreboard();
    res_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        for (int k = 0; k < NUM_K; k++) g_acc[k] = 0;
        g_sat = '0;
      end else begin
        if (if1.out_valid && out_ready) begin
          check_value("sb_result_expected", longint'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < NUM_K; k++) begin
              check_value($sformatf("sb_raw_k%0d", k), kval(if0.out_data, k), kval(e.data, k));
              check_value($sformatf("sb_relu_k%0d", k), kval(if1.out_data, k), relu(kval(e.data, k)));
            end
            check_value("sb_sat_raw", longint'(if0.out_sat), longint'(e.sat));
            check_value("sb_sat_relu", longint'(if1.out_sat), longint'(e.sat));
          end
        end
        check_value("sb_in_ready", longint'(if1.in_ready), longint'(!(if1.out_valid && !out_ready)));
        check_value("sb_valid_match", longint'(if0.out_valid), longint'(if1.out_valid));
        if (in_valid && if1.in_ready) model_beat();
      end
    end
  endtask

  task automatic check_output(input int idx, input vec_t v);
    longint ex;
    check_value($sformatf("vec%0d_valid", idx), longint'(if1.out_valid), 1);
    check_value($sformatf("vec%0d_valid_raw", idx), longint'(if0.out_valid), 1);
    for (int k = 0; k < NUM_K; k++) begin
      ex = (k == 0) ? longint'(v.e0) : longint'(v.er);
      check_value($sformatf("vec%0d_raw_k%0d", idx, k), kval(if0.out_data, k), ex);
      check_value($sformatf("vec%0d_relu_k%0d", idx, k), kval(if1.out_data, k), relu(ex));
    end
    check_value($sformatf("vec%0d_sat", idx), longint'(if1.out_sat), longint'(v.esat));
    check_value($sformatf("vec%0d_sat_raw", idx), longint'(if0.out_sat), longint'(v.esat));
    check_value($sformatf("vec%0d_beat_cnt_end", idx), longint'(if1.beat_cnt), 0);
  endtask

  // Contiguous beats with out_ready high; result must appear two edges after the last beat.
  task automatic apply_stimulus(input int idx, input vec_t v);
    out_ready = 1'b1;
    prod      = fill_prod(v.p0, v.pr);
    for (int b = 0; b < v.nbeats; b++) begin
      in_valid = 1'b1;
      in_last  = (b == v.nbeats - 1);
      @(posedge clk); #1;
      if (b >= 1)
        check_value($sformatf("vec%0d_beat_cnt_b%0d", idx, b), longint'(if1.beat_cnt), longint'(b));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_value($sformatf("vec%0d_not_early", idx), longint'(if1.out_valid), 0);
    @(posedge clk); #1;
    check_output(idx, v);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    g_sat     = '0;
    for (int k = 0; k < NUM_K; k++) g_acc[k] = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    prod      = '0;

    vecs[0] = '{1, 1, 2, 9, 18, 4'b0000};
    vecs[1] = '{3, 100, 100, 2700, 2700, 4'b0000};
    vecs[2] = '{1, -5, -5, -45, -45, 4'b0000};
    vecs[3] = '{15, 16777215, 16777215, 2147483647, 2147483647, 4'b1111};
    vecs[4] = '{1, 1, 1, 9, 9, 4'b0000};
    vecs[5] = '{15, -16777216, -16777216, -2147483647-1, -2147483647-1, 4'b1111};
    vecs[6] = '{2, 1000, -1000, 18000, -18000, 4'b0000};

    fork
      scoreboard();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_value("reset_out_valid", longint'(if1.out_valid), 0);
    check_value("reset_out_data", longint'(if1.out_data != '0), 0);
    check_value("reset_out_sat", longint'(if1.out_sat), 0);
    check_value("reset_beat_cnt", longint'(if1.beat_cnt), 0);
    check_value("reset_in_ready", longint'(if1.in_ready), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) apply_stimulus(i, vecs[i]);
    @(posedge clk); #1;

    $display("[TB] backpressure sequence");
    out_ready = 1'b0;
    prod      = fill_prod(3, 3);
    in_valid  = 1'b1;
    in_last   = 1'b1;
    @(posedge clk); #1;
    prod      = fill_prod(1, 1);
    in_last   = 1'b0;
    @(posedge clk); #1;
    check_value("bp_valid_rise", longint'(if1.out_valid), 1);
    check_value("bp_in_ready_low", longint'(if1.in_ready), 0);
    in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_value($sformatf("bp_hold%0d_valid", c), longint'(if1.out_valid), 1);
      check_value($sformatf("bp_hold%0d_k0", c), kval(if0.out_data, 0), 27);
      check_value($sformatf("bp_hold%0d_k3", c), kval(if1.out_data, 3), 27);
      check_value($sformatf("bp_hold%0d_in_ready", c), longint'(if1.in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_value("bp_release_valid", longint'(if1.out_valid), 0);
    check_value("bp_release_beat_cnt", longint'(if1.beat_cnt), 1);
    @(posedge clk); #1;
    check_value("bp_resume_valid", longint'(if1.out_valid), 1);
    for (int k = 0; k < NUM_K; k++)
      check_value($sformatf("bp_resume_k%0d", k), kval(if1.out_data, k), 18);
    @(posedge clk); #1;

    $display("[TB] reset mid-group sequence");
    prod     = fill_prod(100, 100);
    in_valid = 1'b1;
    in_last  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check_value("midrst_beat_cnt", longint'(if1.beat_cnt), 0);
    check_value("midrst_out_valid", longint'(if1.out_valid), 0);
    check_value("midrst_in_ready", longint'(if1.in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    apply_stimulus(10, vecs[4]);

    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < NUM_K*TAPS; j++) begin
        case ($urandom_range(0, 9))
          8:       prod[j*PROD_W +: PROD_W] = PROD_W'($urandom_range(0, 16777215));
          9:       prod[j*PROD_W +: PROD_W] = PROD_W'(-$signed($urandom_range(1, 16777216)));
          7:       prod[j*PROD_W +: PROD_W] = PROD_W'($urandom);
          default: prod[j*PROD_W +: PROD_W] = PROD_W'($signed($urandom_range(0, 2000)) - 1000);
        endcase
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_value("drain_queue_empty", longint'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
